uart_hex_in: RTL and testbench

Serial receiver that turns ASCII hex text arriving on a UART line into 32-bit words. It is the counterpart of the hex-printing UART transmitter used by the cache hardware benches. It lets a host or a loopback path inject addresses and data into a test block: 8N1 framing, the same bit period as the transmitter, and lines of hex digits terminated by CR or LF.

---
 rtl/uart_hex_in_pkg.sv | 31 +++
 rtl/uart_hex_in_if.sv | 11 +
 rtl/uart_hex_in_rx_byte.sv | 107 ++++++++++
 rtl/uart_hex_in.sv | 64 ++++++
 tb/tb_uart_hex_in.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_hex_in_pkg.sv
// rtl/uart_hex_in_pkg.sv - shared UART divisor, ASCII constants, rx states, hex helpers
package uart_hex_in_pkg;

    localparam int UART_BAUDDIV = 434;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;

    typedef enum logic [2:0] {
        ST_WAITHIGH,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= ASCII_0  && c <= ASCII_0  + 8'd9) ||
               (c >= ASCII_UA && c <= ASCII_UA + 8'd5) ||
               (c >= ASCII_LA && c <= ASCII_LA + 8'd5);
    endfunction

    // Letters of both cases share low nibble 1..6, so +9 maps them to 10..15.
    function automatic logic [3:0] hex_nibble(input logic [7:0] c);
        return (c <= ASCII_0 + 8'd9) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

endpackage

// File: rtl/uart_hex_in_if.sv
// rtl/uart_hex_in_if.sv - serial line in, decoded word and status out
interface uart_hex_in_if;
    logic        rx;
    logic [31:0] value;
    logic        value_good;
    logic        error;
    logic        busy;

    modport master (input rx, output value, output value_good, output error, output busy);
    modport slave  (output rx, input value, input value_good, input error, input busy);
endinterface

// File: rtl/uart_hex_in_rx_byte.sv
// rtl/uart_hex_in_rx_byte.sv - 8N1 byte receiver: synchronizer, baud counter, bit FSM
module uart_rx_byte
    import uart_hex_in_pkg::*;
#(
    parameter int BAUDDIV = UART_BAUDDIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(BAUDDIV + 1);
    localparam logic [CW-1:0] FULL   = CW'(BAUDDIV);
    localparam logic [CW-1:0] HALF   = CW'(BAUDDIV / 2);
    localparam logic [CW-1:0] SETTLE = CW'(2);

    logic            sync1, line;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;

    // Stop-bit sample cycle; the decoder registers its result on this edge.
    logic stop_sample;
    assign stop_sample = (state == ST_STOP) && (cnt == '0);
    assign byte_valid  = stop_sample && line;
    assign frame_err   = stop_sample && !line;
    assign data        = shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b1;
            line   <= 1'b1;
            state  <= ST_WAITHIGH;
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            busy   <= 1'b0;
        end else begin
            sync1 <= rx;
            line  <= sync1;
            case (state)
                // Line must stay high long enough to flush the reset value out of the synchronizer.
                ST_WAITHIGH: begin
                    if (!line) begin
                        cnt <= '0;
                    end else if (cnt == SETTLE) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!line) begin
                        state <= ST_START;
                        cnt   <= HALF;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (line) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state  <= ST_DATA;
                        bitcnt <= '0;
                        cnt    <= FULL;
                    end
                end
                ST_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg <= {line, shreg[7:1]};
                        cnt   <= FULL;
                        if (bitcnt == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= line ? ST_IDLE : ST_WAITHIGH;
                    end
                end
                default: begin
                    state <= ST_WAITHIGH;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_hex_in.sv
// rtl/uart_hex_in.sv - UART receiver turning CR/LF-terminated ASCII hex lines into 32-bit words
module uart_hex_in
    import uart_hex_in_pkg::*;
#(
    parameter int BAUDDIV = UART_BAUDDIV
) (
    input  logic          clk,
    input  logic          reset,
    uart_hex_in_if.master bus
);
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ferr;
    logic [31:0] acc;
    logic [3:0]  count;

    uart_rx_byte #(.BAUDDIV(BAUDDIV)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (bus.rx),
        .data       (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr),
        .busy       (bus.busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            acc            <= '0;
            count          <= '0;
            bus.value      <= '0;
            bus.value_good <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            bus.value_good <= 1'b0;
            bus.error      <= 1'b0;
            if (rx_ferr) begin
                bus.error <= 1'b1;
                acc       <= '0;
                count     <= '0;
            end else if (rx_valid) begin
                if (is_hex(rx_data)) begin
                    // Shifting out the top nibble keeps only the last eight digits.
                    acc <= {acc[27:0], hex_nibble(rx_data)};
                    if (count != 4'd8) begin
                        count <= count + 4'd1;
                    end
                end else if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
                    if (count != 4'd0) begin
                        bus.value      <= acc;
                        bus.value_good <= 1'b1;
                        acc            <= '0;
                        count          <= '0;
                    end
                end else begin
                    bus.error <= 1'b1;
                    acc       <= '0;
                    count     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_hex_in.sv
// tb/tb_uart_hex_in.sv - randomized serial stimulus checked against a line-oriented hex model
module tb_uart_hex_in;

    localparam int B_FAST = 49;
    localparam int B_SLOW = 434;

    typedef struct packed {
        logic        is_err;
        logic [31:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    ev_t  obs_q [2][$];
    ev_t  exp_q [2][$];
    int   digs  [2][$];
    int   vg_cyc [2];
    int   start_cyc;

    string cr = "\015";
    string lf = "\012";

    uart_hex_in_if bus_f ();
    uart_hex_in_if bus_s ();

    uart_hex_in #(.BAUDDIV(B_FAST)) dut_f (.clk(clk), .reset(reset), .bus(bus_f.master));
    uart_hex_in #(.BAUDDIV(B_SLOW)) dut_s (.clk(clk), .reset(reset), .bus(bus_s.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus_f.value_good) begin obs_q[0].push_back({1'b0, bus_f.value}); vg_cyc[0] = cyc; end
            if (bus_f.error)      obs_q[0].push_back({1'b1, 32'h0});
            if (bus_s.value_good) begin obs_q[1].push_back({1'b0, bus_s.value}); vg_cyc[1] = cyc; end
            if (bus_s.error)      obs_q[1].push_back({1'b1, 32'h0});
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: collect digits of the current line; a terminator yields the last eight as a number.
    task automatic model_byte(input bit sel, input logic [7:0] b);
        int d;
        logic [31:0] v;
        d = -1;
        if (b >= 48 && b <= 57) d = b - 48;
        else if (b >= 65 && b <= 70) d = b - 55;
        else if (b >= 97 && b <= 102) d = b - 87;
        if (d >= 0) begin
            digs[sel].push_back(d);
        end else if (b == 13 || b == 10) begin
            if (digs[sel].size() > 0) begin
                v = 0;
                for (int i = (digs[sel].size() > 8 ? digs[sel].size() - 8 : 0); i < digs[sel].size(); i++)
                    v = v * 16 + 32'(digs[sel][i]);
                exp_q[sel].push_back({1'b0, v});
                digs[sel].delete();
            end
        end else begin
            exp_q[sel].push_back({1'b1, 32'h0});
            digs[sel].delete();
        end
    endtask

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) bus_s.rx = v; else bus_f.rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop, input int period, input int gap);
        start_cyc = cyc;
        drive(sel, 1'b0, period);
        for (int k = 0; k < 8; k++) drive(sel, b[k], period);
        drive(sel, stop, period);
        if (stop) model_byte(sel, b);
        else begin
            exp_q[sel].push_back({1'b1, 32'h0});
            digs[sel].delete();
        end
        drive(sel, 1'b1, gap);
    endtask

    task automatic send_str(input bit sel, input string s, input bit jitter);
        int period, gap;
        for (int i = 0; i < s.len(); i++) begin
            period = sel ? B_SLOW + 1 : (jitter ? int'($urandom_range(B_FAST, B_FAST + 2)) : B_FAST + 1);
            gap    = jitter ? int'($urandom_range(0, 30)) : 0;
            send_byte(sel, s[i], 1'b1, period, gap);
        end
    endtask

    task automatic compare(input bit sel, input string tag);
        int n;
        repeat (sel ? 4 * (B_SLOW + 1) : 4 * (B_FAST + 1)) @(negedge clk);
        check({tag, "_count"}, obs_q[sel].size(), exp_q[sel].size());
        n = obs_q[sel].size() < exp_q[sel].size() ? obs_q[sel].size() : exp_q[sel].size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_kind%0d", tag, i), 32'(obs_q[sel][i].is_err), 32'(exp_q[sel][i].is_err));
            check($sformatf("%s_val%0d", tag, i), obs_q[sel][i].val, exp_q[sel][i].val);
        end
        obs_q[sel].delete();
        exp_q[sel].delete();
    endtask

    initial begin
        int bad;
        logic [7:0] ch;
        string pool;
        pool = "0123456789abcdefABCDEF";
        bus_f.rx = 1'b1;
        bus_s.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_value", bus_f.value, 32'h0);
        check("rst_value_good", 32'(bus_f.value_good), 32'h0);
        check("rst_error", 32'(bus_f.error), 32'h0);
        check("rst_busy", 32'(bus_f.busy), 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Real divisor: start fall to value_good = 2 sync + 1 detect + half bit + 9 bits.
        send_str(1, "1", 0);
        send_str(1, cr, 0);
        check("slow_latency", vg_cyc[1] - start_cyc, 3 + (B_SLOW / 2 + 1) + 9 * (B_SLOW + 1));
        compare(1, "slow_1cr");

        drive(1, 1'b0, 50);
        check("glitch_busy_hi", 32'(bus_s.busy), 32'h1);
        drive(1, 1'b0, 50);
        drive(1, 1'b1, 400);
        check("glitch_busy_lo", 32'(bus_s.busy), 32'h0);
        compare(1, "glitch");

        send_str(0, "9ABCDEF0", 0);
        send_str(0, cr, 0);
        check("fast_latency", vg_cyc[0] - start_cyc, 3 + (B_FAST / 2 + 1) + 9 * (B_FAST + 1));
        send_str(0, lf, 0);
        compare(0, "word9abc");

        send_str(0, {"deadbeef", lf, "1", cr, "123456789", cr, "12G4", cr}, 1);
        compare(0, "basic");

        send_byte(0, 8'h31, 1'b0, B_FAST + 1, 20);
        send_str(0, {"5", cr}, 1);
        compare(0, "framing");

        drive(0, 1'b0, 10);
        drive(0, 1'b1, 100);
        check("short_glitch_busy", 32'(bus_f.busy), 32'h0);
        compare(0, "short_glitch");

        // Reset lands in bit 3 of '7' (a zero bit), line stays low past release.
        drive(0, 1'b0, B_FAST + 1);
        for (int k = 0; k < 3; k++) drive(0, 1'b1, B_FAST + 1);
        drive(0, 1'b0, 20);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        digs[0].delete();
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus_f.busy || bus_f.value_good || bus_f.error || bus_f.value != 32'h0) bad++;
        end
        check("rst_hold_quiet", bad, 0);
        drive(0, 1'b1, 10);
        send_str(0, {"A", cr}, 1);
        compare(0, "after_rst");

        for (int w = 0; w < 2; w++)
            send_str(0, {$sformatf("%08X", w == 0 ? 32'h12345678 : 32'h9ABCDEF0), cr, lf}, 1);
        compare(0, "loopback");

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 9))
                0: ch = 8'h0D;
                1: ch = 8'h0A;
                2: ch = 8'h47;
                default: ch = pool[$urandom_range(0, pool.len() - 1)];
            endcase
            send_byte(0, ch, 1'b1, int'($urandom_range(B_FAST, B_FAST + 2)), int'($urandom_range(0, 20)));
        end
        send_str(0, cr, 1);
        compare(0, "random");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
